// File: rtl/clk_edge_gen_pkg.sv
// ---------------------------------------------------------------------------
// clk_edge_gen_pkg
//   Shared definitions for the clk_edge_generator slice:
//     - CNT_W_DEFAULT : default width of the HIGH/LOW phase-length fields
//     - state_t       : waveform FSM states (IDLE, HIGH, LOW)
//     - sat_len()     : maps a zero phase length to one cycle
// ---------------------------------------------------------------------------
package clk_edge_gen_pkg;

    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // A phase can never be shorter than one cycle, so 0 is promoted to 1.
    function automatic logic [31:0] sat_len(input logic [31:0] len);
        return (len == 32'd0) ? 32'd1 : len;
    endfunction

endpackage

// File: rtl/clk_edge_generator_phase_counter.sv
// ---------------------------------------------------------------------------
// edge_phase_counter
//   Loadable down-counter that times one waveform phase. The owner loads it
//   with (length - 1) on phase entry and the phase ends when zero is seen.
//   The counter holds at zero rather than wrapping.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset (count -> 0)
//   load     in   load load_val this cycle (has priority over dec)
//   load_val in   value to load
//   dec      in   decrement request (ignored once at zero)
//   zero     out  count is zero
// ---------------------------------------------------------------------------
module edge_phase_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/clk_edge_generator.sv
// ---------------------------------------------------------------------------
// clk_edge_generator
//   Generates a programmable waveform with per-period HIGH/LOW lengths and
//   one-cycle strobes on the edges it creates. New phase lengths arrive via a
//   valid/ready handshake into a shadow slot and only become active in IDLE
//   or at a period boundary (LOW -> HIGH). Dropping en lets the current period
//   finish before returning to IDLE.
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   en           in   run request (level)
//   cfg_valid    in   new phase lengths offered
//   cfg_ready    out  shadow slot free
//   cfg_high     in   HIGH phase length in cycles (0 treated as 1)
//   cfg_low      in   LOW phase length in cycles (0 treated as 1)
//   wave_out     out  generated waveform (registered)
//   pos_strobe   out  pulse in the first cycle wave_out reads 1
//   neg_strobe   out  pulse in the first cycle wave_out reads 0
//   dual_strobe  out  pos_strobe | neg_strobe (registered)
//   busy         out  FSM not in IDLE
//   oneshot      in   (only with CLK_EDGE_GEN_ONESHOT_EN) a rising en in IDLE
//                     runs exactly one period, then IDLE regardless of en
// Build option: define CLK_EDGE_GEN_ONESHOT_EN to add the oneshot input.
// ---------------------------------------------------------------------------
module clk_edge_generator
    import clk_edge_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_low,
    output logic             wave_out,
    output logic             pos_strobe,
    output logic             neg_strobe,
    output logic             dual_strobe,
    output logic             busy
`ifdef CLK_EDGE_GEN_ONESHOT_EN
    ,
    input  logic             oneshot
`endif
);

    state_t           state;
    logic [CNT_W-1:0] act_h;
    logic [CNT_W-1:0] act_l;
    logic [CNT_W-1:0] sh_h;
    logic [CNT_W-1:0] sh_l;
    logic             pending;

    logic [CNT_W-1:0] eff_h;
    logic [CNT_W-1:0] cnt_load_val;
    logic             accept;
    logic             apply_cfg;
    logic             high_done;
    logic             low_done;
    logic             start;
    logic             cont;
    logic             go_high;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;

    assign cfg_ready = ~pending;
    assign accept    = cfg_valid & ~pending;
    assign busy      = (state != IDLE);

    assign high_done = (state == HIGH) && cnt_zero;
    assign low_done  = (state == LOW)  && cnt_zero;

`ifdef CLK_EDGE_GEN_ONESHOT_EN
    logic en_d;
    logic one_run;

    // In oneshot mode only a fresh rising en starts a period, and the period
    // it starts is never continued.
    assign start = oneshot ? (en & ~en_d) : en;
    assign cont  = en & ~one_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_d    <= 1'b0;
            one_run <= 1'b0;
        end else begin
            en_d <= en;
            if ((state == IDLE) && start) begin
                one_run <= oneshot;
            end else if (low_done) begin
                one_run <= 1'b0;
            end
        end
    end
`else
    assign start = en;
    assign cont  = en;
`endif

    assign go_high   = ((state == IDLE) && start) || (low_done && cont);
    assign apply_cfg = pending && ((state == IDLE) || low_done);

    // A HIGH phase entered on the same edge that a pending config is applied
    // must already use the new length, so take it straight from the shadow.
    assign eff_h = pending ? sh_h : act_h;

    // LOW always belongs to the period already under way, so it uses act_l.
    assign cnt_load     = go_high | high_done;
    assign cnt_load_val = go_high ? (eff_h - CNT_W'(1)) : (act_l - CNT_W'(1));
    assign cnt_dec      = (state != IDLE);

    edge_phase_counter #(
        .CNT_W(CNT_W)
    ) u_phase_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (cnt_load),
        .load_val(cnt_load_val),
        .dec     (cnt_dec),
        .zero    (cnt_zero)
    );

    // Accept and apply cannot coincide: apply needs a pending shadow while
    // accept needs an empty one, so a payload accepted at a boundary always
    // waits for the following boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_h   <= CNT_W'(1);
            act_l   <= CNT_W'(1);
            sh_h    <= CNT_W'(1);
            sh_l    <= CNT_W'(1);
            pending <= 1'b0;
        end else if (accept) begin
            sh_h    <= CNT_W'(sat_len(32'(cfg_high)));
            sh_l    <= CNT_W'(sat_len(32'(cfg_low)));
            pending <= 1'b1;
        end else if (apply_cfg) begin
            act_h   <= sh_h;
            act_l   <= sh_l;
            pending <= 1'b0;
        end
    end

    // Waveform FSM with registered wave and strobe outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wave_out    <= 1'b0;
            pos_strobe  <= 1'b0;
            neg_strobe  <= 1'b0;
            dual_strobe <= 1'b0;
        end else begin
            pos_strobe  <= 1'b0;
            neg_strobe  <= 1'b0;
            dual_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (go_high) begin
                        state       <= HIGH;
                        wave_out    <= 1'b1;
                        pos_strobe  <= 1'b1;
                        dual_strobe <= 1'b1;
                    end
                end
                HIGH: begin
                    if (high_done) begin
                        state       <= LOW;
                        wave_out    <= 1'b0;
                        neg_strobe  <= 1'b1;
                        dual_strobe <= 1'b1;
                    end
                end
                LOW: begin
                    if (low_done) begin
                        if (cont) begin
                            state       <= HIGH;
                            wave_out    <= 1'b1;
                            pos_strobe  <= 1'b1;
                            dual_strobe <= 1'b1;
                        end else begin
                            state    <= IDLE;
                            wave_out <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    wave_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_edge_generator.sv
// ---------------------------------------------------------------------------
// tb_clk_edge_generator
//   Self-checking bench for clk_edge_generator. The reference model tracks
//   the position inside the current period and derives the waveform as
//   "position < H", with strobes taken from transitions of that waveform.
// ---------------------------------------------------------------------------
module tb_clk_edge_generator;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_high;
    logic [W-1:0] cfg_low;
    logic         wave_out;
    logic         pos_strobe;
    logic         neg_strobe;
    logic         dual_strobe;
    logic         busy;
    logic         oneshot;

    int n_checks = 0;
    int n_fail   = 0;

    clk_edge_generator #(
        .CNT_W(W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_high   (cfg_high),
        .cfg_low    (cfg_low),
        .wave_out   (wave_out),
        .pos_strobe (pos_strobe),
        .neg_strobe (neg_strobe),
        .dual_strobe(dual_strobe),
        .busy       (busy)
`ifdef CLK_EDGE_GEN_ONESHOT_EN
        ,
        .oneshot    (oneshot)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    bit m_run, m_pend, m_one_run, m_en_d;
    bit m_wave, m_pos, m_neg, m_prev;
    int m_idx, m_h, m_l, m_sh_h, m_sh_l;

    function automatic void model_reset();
        m_run = 0; m_pend = 0; m_one_run = 0; m_en_d = 0;
        m_wave = 0; m_pos = 0; m_neg = 0; m_prev = 0;
        m_idx = 0; m_h = 1; m_l = 1; m_sh_h = 1; m_sh_l = 1;
    endfunction

    function automatic void model_apply();
        if (m_pend) begin
            m_h = m_sh_h; m_l = m_sh_l; m_pend = 0;
        end
    endfunction

    // One clock edge of the specified behaviour, using the inputs present.
    function automatic void model_step();
        bit acc;
        bit start;
        bit os;
        os    = (oneshot === 1'b1);
        acc   = (cfg_valid === 1'b1) && !m_pend;
`ifdef CLK_EDGE_GEN_ONESHOT_EN
        start = os ? (en && !m_en_d) : en;
`else
        start = en;
        os    = 0;
`endif
        if (!m_run) begin
            model_apply();
            if (start) begin
                m_run = 1; m_idx = 0; m_one_run = os;
            end
        end else begin
            m_idx++;
            if (m_idx == m_h + m_l) begin
                model_apply();
                if (en && !m_one_run) m_idx = 0;
                else begin m_run = 0; m_one_run = 0; end
            end
        end
        if (acc) begin
            m_sh_h = (cfg_high == 0) ? 1 : int'(cfg_high);
            m_sh_l = (cfg_low  == 0) ? 1 : int'(cfg_low);
            m_pend = 1;
        end
        m_en_d = en;
        m_prev = m_wave;
        m_wave = m_run && (m_idx < m_h);
        m_pos  = m_wave && !m_prev;
        m_neg  = !m_wave && m_prev;
    endfunction

    task automatic checkVal(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput();
        checkVal("model_wave",  wave_out,    m_wave);
        checkVal("model_pos",   pos_strobe,  m_pos);
        checkVal("model_neg",   neg_strobe,  m_neg);
        checkVal("model_dual",  dual_strobe, m_pos | m_neg);
        checkVal("model_busy",  busy,        m_run);
        checkVal("model_ready", cfg_ready,   !m_pend);
    endtask

    task automatic checkResetValues(input string name);
        checkVal({name, "_wave"},  wave_out,    1'b0);
        checkVal({name, "_pos"},   pos_strobe,  1'b0);
        checkVal({name, "_neg"},   neg_strobe,  1'b0);
        checkVal({name, "_dual"},  dual_strobe, 1'b0);
        checkVal({name, "_busy"},  busy,        1'b0);
        checkVal({name, "_ready"}, cfg_ready,   1'b1);
    endtask

    task automatic applyStimulus(input logic e, input logic v,
                                 input logic [W-1:0] h, input logic [W-1:0] l);
        en        = e;
        cfg_valid = v;
        cfg_high  = h;
        cfg_low   = l;
    endtask

    // Advance one clock, step the model, then compare 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        checkOutput();
    endtask

    // Asynchronous reset asserted away from the clock edge; outputs must
    // clear before any edge arrives.
    task automatic doReset();
        applyStimulus(1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        model_reset();
        #1;
        checkResetValues("async_reset");
        repeat (2) begin
            @(posedge clk);
            #1;
            checkResetValues("reset_hold");
        end
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic         en;
        logic         valid;
        logic [W-1:0] h;
        logic [W-1:0] l;
        logic         wave;
        logic         pos;
        logic         neg;
        logic         ready;
        logic         busy;
    } vec_t;

    vec_t vec[13];

    initial begin
        int negs;
        int poss;
        int cyc;
        logic [4:0] shape;

        // Test 1: reset held with en=1 and a config offered.
        oneshot = 1'b0;
        rst_n   = 1'b0;
        applyStimulus(1'b1, 1'b1, 8'd3, 8'd2);
        model_reset();
        repeat (4) begin
            @(posedge clk);
            #1;
            checkResetValues("reset");
        end
        applyStimulus(1'b0, 1'b0, '0, '0);
        rst_n = 1'b1;

        // Test 2: H=3, L=2 free-running, period 5 with neg 3 cycles after pos.
        //              en  valid  h     l     wave pos neg rdy busy
        vec[0]  = '{1'b0, 1'b1, 8'd3, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[1]  = '{1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[2]  = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vec[3]  = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vec[4]  = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vec[5]  = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vec[6]  = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vec[7]  = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vec[8]  = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vec[9]  = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vec[10] = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vec[11] = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vec[12] = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vec[i].en, vec[i].valid, vec[i].h, vec[i].l);
            tick();
            checkVal("vec_wave",  wave_out,    vec[i].wave);
            checkVal("vec_pos",   pos_strobe,  vec[i].pos);
            checkVal("vec_neg",   neg_strobe,  vec[i].neg);
            checkVal("vec_dual",  dual_strobe, vec[i].pos | vec[i].neg);
            checkVal("vec_ready", cfg_ready,   vec[i].ready);
            checkVal("vec_busy",  busy,        vec[i].busy);
        end

        // Test 3: push H=1, L=4 in the second HIGH cycle of a 3/2 period.
        applyStimulus(1'b1, 1'b1, 8'd1, 8'd4);
        tick();
        checkVal("push_ready", cfg_ready, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, '0);
        repeat (3) begin
            tick();
            checkVal("push_ready_held", cfg_ready, 1'b0);
        end
        tick();
        checkVal("boundary_ready", cfg_ready, 1'b1);
        checkVal("boundary_pos",   pos_strobe, 1'b1);
        shape = 5'b10000;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkVal("new_period_wave", wave_out, shape[i]);
        end

        // Test 4: en dropped in HIGH of a 3/2 period -> graceful stop.
        doReset();
        applyStimulus(1'b0, 1'b1, 8'd3, 8'd2);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
        tick();
        applyStimulus(1'b1, 1'b0, '0, '0);
        tick();
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
        negs = 0; poss = 0; cyc = 0;
        while (busy && cyc < 20) begin
            tick();
            negs += int'(neg_strobe);
            poss += int'(pos_strobe);
            cyc++;
        end
        checkVal("stop_busy",   busy,     1'b0);
        checkVal("stop_wave",   wave_out, 1'b0);
        checkInt("stop_cycles", cyc,  4);
        checkInt("stop_negs",   negs, 1);
        checkInt("stop_poss",   poss, 0);

        // Test 5: zero lengths behave as 1/1 (after a non-default 3/2).
        doReset();
        applyStimulus(1'b0, 1'b1, 8'd3, 8'd2);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
        tick();
        applyStimulus(1'b0, 1'b1, 8'd0, 8'd0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
        tick();
        applyStimulus(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 8; i++) begin
            tick();
            checkVal("zero_len_dual", dual_strobe, 1'b1);
            checkVal("zero_len_wave", wave_out, (i % 2) == 0);
        end

`ifdef CLK_EDGE_GEN_ONESHOT_EN
        // Test 6: oneshot with en held -> single 2/2 period then idle.
        doReset();
        oneshot = 1'b1;
        applyStimulus(1'b0, 1'b1, 8'd2, 8'd2);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
        tick();
        applyStimulus(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 12; i++) begin
            tick();
            checkVal("oneshot_wave", wave_out, i < 2);
            checkVal("oneshot_busy", busy,     i < 4);
        end
        oneshot = 1'b0;
`endif

        // Randomised run against the model, with occasional async resets.
        doReset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(399) == 0) doReset();
            en        = ($urandom_range(15) == 0) ? ~en : en;
            cfg_valid = ($urandom_range(5) == 0);
            cfg_high  = W'($urandom_range(4));
            cfg_low   = W'($urandom_range(4));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
